gcd_stein_hs: RTL and testbench



---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_stein_hs.sv | 137 +++++++++++++
 tb/tb_gcd_stein_hs.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the Stein binary-GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SUB   = 2'd2,
        ST_DONE  = 2'd3
    } gcd_state_e;

    // Ceiling log2, used to size the common power-of-two count.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_stein_hs.sv
// Binary GCD (Stein) engine with valid/ready handshakes, zero-operand handling
// and a saturating per-operation cycle counter.
module gcd_stein_hs
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             both_zero,
    output logic [CYC_W-1:0] cycles
);

    localparam int K_W = clog2(WIDTH + 1);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             both_zero_q, both_zero_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CYC_W-1:0] cnt_inc;

    // The counter includes the current cycle, so the DONE transition records cnt_inc.
    assign cnt_inc = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        gcd_d       = gcd_q;
        both_zero_d = both_zero_q;
        cycles_d    = cycles_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_inc;
                if (x_q == '0 || y_q == '0) begin
                    gcd_d       = x_q | y_q;
                    both_zero_d = (x_q == '0) && (y_q == '0);
                    cycles_d    = cnt_inc;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + 1'b1;
                end else begin
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                cnt_d = cnt_inc;
                if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q == y_q) begin
                    // Result never exceeds min(a,b), so restoring the shared twos cannot overflow.
                    gcd_d       = x_q << k_q;
                    both_zero_d = 1'b0;
                    cycles_d    = cnt_inc;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (x_q > y_q) begin
                    x_d = (x_q - y_q) >> 1;
                end else begin
                    y_d = (y_q - x_q) >> 1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            gcd_q       <= '0;
            both_zero_q <= 1'b0;
            cycles_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            gcd_q       <= gcd_d;
            both_zero_q <= both_zero_d;
            cycles_q    <= cycles_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign gcd       = gcd_q;
    assign both_zero = both_zero_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_stein_hs.sv
// Self-checking bench for gcd_stein_hs: directed cases plus random pairs
// checked against a Euclid reference model.
module tb_gcd_stein_hs;

    localparam int WIDTH   = 32;
    localparam int CYC_W   = 16;
    localparam int MAX_CYC = 2 * WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd;
    logic             both_zero;
    logic [CYC_W-1:0] cycles;

    int tests_run;
    int tests_failed;

    gcd_stein_hs #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd       (gcd),
        .both_zero (both_zero),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] t;
        m = p;
        n = q;
        while (n != 0) begin
            t = m % n;
            m = n;
            n = t;
        end
        return m;
    endfunction

    // Issue one operand pair, wait for the result and optionally drain it.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit drain,
                          output logic [WIDTH-1:0] g, output logic bz,
                          output logic [CYC_W-1:0] cyc, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        if (!out_valid) chk("result_timeout", 1'b0, 1'b1);
        g   = gcd;
        bz  = both_zero;
        cyc = cycles;
        chk("in_ready_in_done", in_ready, 1'b0);
        if (drain) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("drain_out_valid", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b1);
        end
    endtask

    task automatic check_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] g;
        logic             bz;
        logic [CYC_W-1:0] cyc;
        int               lat;
        run_op(av, bv, 1'b1, g, bz, cyc, lat);
        chk({tag, "_gcd"}, g, ref_gcd(av, bv));
        chk({tag, "_bz"}, bz, (av == 0 && bv == 0));
        chk({tag, "_lat"}, lat, cyc);
        chk({tag, "_bound"}, (cyc >= 1 && cyc <= MAX_CYC), 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] g_hold;
        logic             bz;
        logic [CYC_W-1:0] cyc;
        logic [CYC_W-1:0] cyc_hold;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               lat;
        int               sel;

        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_gcd", gcd, 0);
        chk("rst_both_zero", both_zero, 1'b0);
        chk("rst_cycles", cycles, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(48, 18, 1'b1, g, bz, cyc, lat);
        chk("d48_18_gcd", g, 6);
        chk("d48_18_bz", bz, 1'b0);
        chk("d48_18_cycles", cyc, 7);
        chk("d48_18_lat", lat, 7);

        run_op(0, 35, 1'b1, g, bz, cyc, lat);
        chk("d0_35_gcd", g, 35);
        chk("d0_35_bz", bz, 1'b0);
        chk("d0_35_cycles", cyc, 1);
        chk("d0_35_lat", lat, 1);

        run_op(0, 0, 1'b1, g, bz, cyc, lat);
        chk("d0_0_gcd", g, 0);
        chk("d0_0_bz", bz, 1'b1);
        chk("d0_0_cycles", cyc, 1);

        run_op(32'h8000_0000, 32'h0010_0000, 1'b1, g, bz, cyc, lat);
        chk("dpow2_gcd", g, 32'h0010_0000);
        chk("dpow2_bz", bz, 1'b0);

        run_op(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, g, bz, cyc, lat);
        chk("dprime_gcd", g, 1);
        chk("dprime_bound", (cyc <= MAX_CYC), 1'b1);

        run_op(77, 77, 1'b1, g, bz, cyc, lat);
        chk("d77_gcd", g, 77);

        // Backpressure: result held, in_valid pulses ignored.
        run_op(48, 18, 1'b0, g_hold, bz, cyc_hold, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_gcd", gcd, g_hold);
            chk("bp_cycles", cycles, cyc_hold);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", out_valid, 1'b0);
        chk("bp_release_in_ready", in_ready, 1'b1);
        check_op("after_bp", 91, 35);

        // Reset while in SUB of (48,18).
        @(negedge clk);
        in_valid = 1'b1;
        a = 48;
        b = 18;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_gcd", gcd, 0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_cycles", cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(12, 8, 1'b1, g, bz, cyc, lat);
        chk("post_rst_gcd", g, 4);

        // Random pairs, mixing full-range, small, shared-power-of-two, equal and zero cases.
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 7);
            ra = $urandom;
            rb = $urandom;
            case (sel)
                0: rb = ra;
                1: ra = '0;
                2: begin
                    ra = $urandom_range(1, 1000) << $urandom_range(0, 20);
                    rb = $urandom_range(1, 1000) << $urandom_range(0, 20);
                end
                3: begin
                    ra = $urandom_range(0, 255);
                    rb = $urandom_range(0, 255);
                end
                4: begin
                    ra = $urandom_range(1, 65535) * 32'd6007;
                    rb = $urandom_range(1, 65535) * 32'd6007;
                end
                default: ;
            endcase
            check_op("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
